// File: rtl/branch_issue_queue_if.sv
// branch_issue_queue_if: dispatch, CDB, flush and issue signals of the branch issue queue (master = producer/consumer side, slave = queue)
interface branch_issue_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int TAG_WIDTH  = 6,
  parameter int DEPTH      = 4
);
  logic                         i_disp_valid;
  logic                         o_disp_ready;
  logic                         i_disp_op1_rdy;
  logic                         i_disp_op2_rdy;
  logic [TAG_WIDTH-1:0]         i_disp_op1_tag;
  logic [TAG_WIDTH-1:0]         i_disp_op2_tag;
  logic [DATA_WIDTH-1:0]        i_disp_op1;
  logic [DATA_WIDTH-1:0]        i_disp_op2;
  logic [DATA_WIDTH-1:0]        i_disp_pc;
  logic [DATA_WIDTH-1:0]        i_disp_imm;
  logic [2:0]                   i_disp_funct3;
  logic [ROB_WIDTH-1:0]         i_disp_rob_tag;
  logic                         i_cdb_valid;
  logic [TAG_WIDTH-1:0]         i_cdb_tag;
  logic [DATA_WIDTH-1:0]        i_cdb_data;
  logic                         i_flush;
  logic                         o_iss_valid;
  logic [DATA_WIDTH-1:0]        o_iss_op1;
  logic [DATA_WIDTH-1:0]        o_iss_op2;
  logic [DATA_WIDTH-1:0]        o_iss_pc;
  logic [DATA_WIDTH-1:0]        o_iss_imm;
  logic [2:0]                   o_iss_funct3;
  logic [ROB_WIDTH-1:0]         o_iss_rob_tag;
  logic [$clog2(DEPTH+1)-1:0]   o_count;
  modport master (
    output i_disp_valid, i_disp_op1_rdy, i_disp_op2_rdy, i_disp_op1_tag, i_disp_op2_tag,
           i_disp_op1, i_disp_op2, i_disp_pc, i_disp_imm, i_disp_funct3, i_disp_rob_tag,
           i_cdb_valid, i_cdb_tag, i_cdb_data, i_flush,
    input  o_disp_ready, o_iss_valid, o_iss_op1, o_iss_op2, o_iss_pc, o_iss_imm,
           o_iss_funct3, o_iss_rob_tag, o_count
  );
  modport slave (
    input  i_disp_valid, i_disp_op1_rdy, i_disp_op2_rdy, i_disp_op1_tag, i_disp_op2_tag,
           i_disp_op1, i_disp_op2, i_disp_pc, i_disp_imm, i_disp_funct3, i_disp_rob_tag,
           i_cdb_valid, i_cdb_tag, i_cdb_data, i_flush,
    output o_disp_ready, o_iss_valid, o_iss_op1, o_iss_op2, o_iss_pc, o_iss_imm,
           o_iss_funct3, o_iss_rob_tag, o_count
  );
endinterface

// File: rtl/branch_issue_queue.sv
// branch_issue_queue: collapsing in-order-select branch reservation queue; clk/rst plus bus (dispatch in, CDB wakeup, flush, registered issue out, count)
module branch_issue_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int TAG_WIDTH  = 6,
  parameter int DEPTH      = 4
) (
  input logic                clk,
  input logic                rst,
  branch_issue_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef struct packed {
    logic                  valid;
    logic                  r1;
    logic                  r2;
    logic [TAG_WIDTH-1:0]  t1;
    logic [TAG_WIDTH-1:0]  t2;
    logic [DATA_WIDTH-1:0] v1;
    logic [DATA_WIDTH-1:0] v2;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] imm;
    logic [2:0]            f3;
    logic [ROB_WIDTH-1:0]  rob;
  } entry_t;
  entry_t                q [DEPTH];
  entry_t                w [DEPTH];
  entry_t                n [DEPTH];
  entry_t                d;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         pos;
  logic                  ready;
  logic                  fire;
  logic                  sel;
  logic [IW-1:0]         sel_idx;
  logic                  iss_v;
  logic [DATA_WIDTH-1:0] iss_op1;
  logic [DATA_WIDTH-1:0] iss_op2;
  logic [DATA_WIDTH-1:0] iss_pc;
  logic [DATA_WIDTH-1:0] iss_imm;
  logic [2:0]            iss_f3;
  logic [ROB_WIDTH-1:0]  iss_rob;
  logic                  b1;
  logic                  b2;
  assign ready = cnt != CW'(DEPTH);
  assign fire  = bus.i_disp_valid && ready && !bus.i_flush;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w[i]    = q[i];
      w[i].r1 = q[i].r1 | (q[i].valid && bus.i_cdb_valid && q[i].t1 == bus.i_cdb_tag);
      w[i].r2 = q[i].r2 | (q[i].valid && bus.i_cdb_valid && q[i].t2 == bus.i_cdb_tag);
      w[i].v1 = (!q[i].r1 && w[i].r1) ? bus.i_cdb_data : q[i].v1;
      w[i].v2 = (!q[i].r2 && w[i].r2) ? bus.i_cdb_data : q[i].v2;
    end
  end
  always_comb begin
    sel     = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q[i].valid && q[i].r1 && q[i].r2) begin
        sel     = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end
  always_comb begin
    b1 = !bus.i_disp_op1_rdy && bus.i_cdb_valid && bus.i_cdb_tag == bus.i_disp_op1_tag;
    b2 = !bus.i_disp_op2_rdy && bus.i_cdb_valid && bus.i_cdb_tag == bus.i_disp_op2_tag;
    d.valid = 1'b1;
    d.r1    = bus.i_disp_op1_rdy | b1;
    d.r2    = bus.i_disp_op2_rdy | b2;
    d.t1    = bus.i_disp_op1_tag;
    d.t2    = bus.i_disp_op2_tag;
    d.v1    = b1 ? bus.i_cdb_data : bus.i_disp_op1;
    d.v2    = b2 ? bus.i_cdb_data : bus.i_disp_op2;
    d.pc    = bus.i_disp_pc;
    d.imm   = bus.i_disp_imm;
    d.f3    = bus.i_disp_funct3;
    d.rob   = bus.i_disp_rob_tag;
    pos     = cnt - CW'(sel);
    for (int i = 0; i < DEPTH - 1; i++)
      n[i] = (sel && i >= int'(sel_idx)) ? w[i+1] : w[i];
    n[DEPTH-1] = sel ? '0 : w[DEPTH-1];
    for (int i = 0; i < DEPTH; i++)
      if (fire && pos == CW'(i)) n[i] = d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '{default: '0};
      cnt     <= '0;
      iss_v   <= 1'b0;
      iss_op1 <= '0;
      iss_op2 <= '0;
      iss_pc  <= '0;
      iss_imm <= '0;
      iss_f3  <= '0;
      iss_rob <= '0;
    end else if (bus.i_flush) begin
      q     <= '{default: '0};
      cnt   <= '0;
      iss_v <= 1'b0;
    end else begin
      q     <= n;
      cnt   <= cnt + CW'(fire) - CW'(sel);
      iss_v <= sel;
      if (sel) begin
        iss_op1 <= q[sel_idx].v1;
        iss_op2 <= q[sel_idx].v2;
        iss_pc  <= q[sel_idx].pc;
        iss_imm <= q[sel_idx].imm;
        iss_f3  <= q[sel_idx].f3;
        iss_rob <= q[sel_idx].rob;
      end
    end
  end
  assign bus.o_disp_ready  = ready;
  assign bus.o_count       = cnt;
  assign bus.o_iss_valid   = iss_v;
  assign bus.o_iss_op1     = iss_op1;
  assign bus.o_iss_op2     = iss_op2;
  assign bus.o_iss_pc      = iss_pc;
  assign bus.o_iss_imm     = iss_imm;
  assign bus.o_iss_funct3  = iss_f3;
  assign bus.o_iss_rob_tag = iss_rob;
endmodule
